// File: rtl/tt_um_hoene_input_arbiter.sv
// Two-link input arbiter: grants DIN or BIN for one frame, forwards its bits 1 clk late, flushes on release.
// No backpressure; a strobe on the non-granted link is dropped and only raises the sticky collision flag.
module tt_um_hoene_input_arbiter #(
   parameter int IDLE_CYCLES = 1000,
   parameter int BITS        = 32,
   parameter bit PRIO_DIN    = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       din_data,
   input  logic       din_clk,
   input  logic       din_sync,
   input  logic       bin_data,
   input  logic       bin_clk,
   input  logic       bin_sync,
   output logic       out_data,
   output logic       out_clk,
   output logic       out_sync,
   output logic       in0selected,
   output logic [4:0] bit_counter,
   output logic       word_error,
   output logic       timeout,
   output logic       collision
);
   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_LOCK_DIN = 2'd1;
   localparam logic [1:0] ST_LOCK_BIN = 2'd2;
   localparam logic [1:0] ST_FLUSH    = 2'd3;

   localparam int              IW        = $clog2(IDLE_CYCLES);
   localparam logic [IW-1:0]   IDLE_LAST = IW'(IDLE_CYCLES - 1);
   localparam logic [4:0]      BIT_LAST  = 5'(BITS - 1);

   logic [1:0]    state;
   logic [IW-1:0] idle_cnt;
   logic          din_cand, bin_cand, take_din;
   logic          locked, lock_din;
   logic          g_sync, g_clk, g_data, other_cand;
   logic          rel_sync, rel_idle;
   logic [4:0]    next_idx;

   always_comb begin
      din_cand   = din_sync & din_clk;
      bin_cand   = bin_sync & bin_clk;
      take_din   = din_cand & (~bin_cand | PRIO_DIN);
      lock_din   = (state == ST_LOCK_DIN);
      locked     = lock_din | (state == ST_LOCK_BIN);
      g_sync     = lock_din ? din_sync : bin_sync;
      g_clk      = lock_din ? din_clk  : bin_clk;
      g_data     = lock_din ? din_data : bin_data;
      other_cand = lock_din ? bin_cand : din_cand;
      rel_sync   = locked & ~g_sync;
      rel_idle   = locked & g_sync & ~g_clk & (idle_cnt == IDLE_LAST);
      // bit_counter holds the index of the last forwarded bit until the cycle after its strobe
      if (!out_clk)
         next_idx = bit_counter;
      else if (bit_counter == BIT_LAST)
         next_idx = 5'd0;
      else
         next_idx = bit_counter + 5'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         out_data    <= 1'b0;
         out_clk     <= 1'b0;
         out_sync    <= 1'b0;
         in0selected <= 1'b1;
         bit_counter <= 5'd0;
         word_error  <= 1'b0;
         timeout     <= 1'b0;
         collision   <= 1'b0;
         idle_cnt    <= '0;
      end else begin
         out_clk    <= 1'b0;
         word_error <= 1'b0;
         timeout    <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (din_cand | bin_cand) begin
                  state       <= take_din ? ST_LOCK_DIN : ST_LOCK_BIN;
                  out_sync    <= 1'b1;
                  out_clk     <= 1'b1;
                  out_data    <= take_din ? din_data : bin_data;
                  in0selected <= take_din;
                  bit_counter <= 5'd0;
                  collision   <= 1'b0;
                  idle_cnt    <= '0;
               end
            end
            ST_LOCK_DIN, ST_LOCK_BIN: begin
               if (other_cand)
                  collision <= 1'b1;
               if (rel_sync | rel_idle) begin
                  state       <= ST_FLUSH;
                  out_sync    <= 1'b0;
                  out_data    <= 1'b0;
                  bit_counter <= 5'd0;
                  idle_cnt    <= '0;
                  word_error  <= (next_idx != 5'd0);
                  timeout     <= rel_idle;
               end else begin
                  bit_counter <= next_idx;
                  if (g_clk) begin
                     out_clk  <= 1'b1;
                     out_data <= g_data;
                     idle_cnt <= '0;
                  end else begin
                     idle_cnt <= idle_cnt + 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule
